pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register; replaces the hand-written fetch, control-vector and writeback registers in the pipelined CPU.
- Carries a payload word plus a PC/tag sideband between stages.
- Uses valid/ready flow control, with flush-to-NOP for branches and interrupts.
- Optional 2-entry skid buffer breaks the combinational ready path.

Parameters:
- DATA_W, 18, payload width (18 = instruction word; wider for control vectors).
- TAG_W, 10, sideband width (PC address).
- NOP_VAL, 0, payload value presented when the stage holds no valid entry or is flushed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts an entry this cycle
- in_data  in  DATA_W  upstream payload
- in_tag  in  TAG_W  upstream PC/tag
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream consumes this cycle (0 = stall)
- out_data  out  DATA_W  payload; NOP_VAL when out_valid=0
- out_tag  out  TAG_W  tag; 0 when out_valid=0
- flush  in  1  synchronous kill of all held entries
- occupancy  out  2  number of held entries (0..2)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state EMPTY, out_valid=0, out_data=NOP_VAL, out_tag=0, occupancy=0.
  - in_ready=1 once reset is released.
- Transfer rules:
  - Input accept when in_valid & in_ready at a clk edge.
  - Output consume when out_valid & out_ready at a clk edge.
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N.
- States without the skid buffer:
  - EMPTY, FULL.
  - in_ready = out_ready | ~out_valid (combinational).
  - EMPTY, accept -> FULL.
  - FULL, consume with no accept -> EMPTY.
  - FULL, consume and accept -> FULL with the new entry.
  - FULL, no consume -> hold payload and tag unchanged.
- States with the skid buffer: see Optional Feature.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush.
- flush (synchronous, highest priority):
  - On the edge where flush=1, all held entries are discarded and the state becomes EMPTY.
  - An in_valid entry presented in the same cycle is also discarded.
  - A consume in that same cycle still counts downstream; the stage does not re-present that entry.
- Reset mid-transfer: rst_n low at any time forces EMPTY immediately, with no clock needed.
- Sideband rule: out_tag always belongs to the same entry as out_data.
- occupancy: 0 = EMPTY, 1 = FULL, 2 = SKID.
- Output drive: out_data and out_tag come from the head register. When that register is invalid, they are forced to NOP_VAL / 0.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - Adds a second (skid) entry and state SKID.
  - in_ready is a flop output equal to (state != SKID); there is no combinational path from out_ready.
  - FULL, accept, no consume -> SKID; the new entry goes to the skid register.
  - SKID, consume -> FULL; the skid entry moves to the head.
  - SKID never accepts, because in_ready=0.
  - Throughput stays 1 entry/cycle under continuous flow.
- Not defined:
  - Single-entry behaviour as described above, with combinational in_ready.
  - occupancy never exceeds 1.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef pipe_state_t (EMPTY, FULL, SKID);
  - constant RAT_INSTR_W = 18;
  - constant RAT_PC_W = 10;
  - a default NOP instruction constant.
- Natural sub-module: pipe_entry_reg, one valid+data+tag register with load/clear. It is instantiated once for the head and, under the macro, once for the skid entry.

Test Plan:
1. Reset: rst_n=0 with in_valid=1, in_data=18'h3ABCD -> out_valid=0, out_data=0, occupancy=0. Release reset -> in_ready=1.
2. Streaming: out_ready=1, in_data=1,2,3 with tags 10'h010,10'h011,10'h012 on consecutive cycles -> same values on out_* one cycle later, in order, no gaps.
3. Stall: with out_ready=0, hold data 18'h00042 and tag 10'h020 for 3 cycles -> out_data stays 18'h00042. Without the macro, in_ready=0 during the stall. With the macro, one more entry is accepted, occupancy=2, then in_ready=0.
4. Release after skid (macro defined): out_ready 0->1 -> entries 18'h00042 then 18'h00043 delivered on consecutive cycles; occupancy goes 2,1,0.
5. Flush: state FULL (or SKID) with in_valid=1 and flush=1 for one cycle -> next cycle out_valid=0, out_data=NOP_VAL, occupancy=0. The flushed in_data never appears.
6. Async reset mid-stall: assert rst_n=0 between clock edges while FULL -> out_valid drops before the next edge and the held entry is lost.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared state type and default widths for pipeline stage registers.
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} pipe_state_t;
   localparam int RAT_INSTR_W = 18;
   localparam int RAT_PC_W = 10;
   localparam logic [RAT_INSTR_W-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready channel carrying a payload word and PC/tag sideband.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = RAT_INSTR_W,
   parameter int TAG_W = RAT_PC_W
);
   logic valid;
   logic ready;
   logic [DATA_W-1:0] data;
   logic [TAG_W-1:0] tag;
   modport master (output valid, data, tag, input ready);
   modport slave (input valid, data, tag, output ready);
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// pipe_entry_reg: one valid+data+tag register; clear wins over load.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = RAT_INSTR_W,
   parameter int TAG_W = RAT_PC_W
) (
   input logic clk,
   input logic rst_n,
   input logic load,
   input logic clear,
   input logic [DATA_W-1:0] d_data,
   input logic [TAG_W-1:0] d_tag,
   output logic valid,
   output logic [DATA_W-1:0] data,
   output logic [TAG_W-1:0] tag
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         data <= '0;
         tag <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data <= d_data;
         tag <= d_tag;
      end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with flush-to-NOP.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = RAT_INSTR_W,
   parameter int TAG_W = RAT_PC_W,
   parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSTR)
) (
   input logic clk,
   input logic rst_n,
   pipe_stage_reg_if.slave in_if,
   pipe_stage_reg_if.master out_if,
   input logic flush,
   output logic [1:0] occupancy
);
   pipe_state_t state_q, state_d;
   logic accept, consume, head_load, head_clr, head_valid;
   logic [DATA_W-1:0] head_data, head_src_data;
   logic [TAG_W-1:0] head_tag, head_src_tag;
   assign accept = in_if.valid & in_if.ready;
   assign consume = head_valid & out_if.ready;
`ifdef PIPE_STAGE_SKID_EN
   logic skid_load, skid_clr, skid_valid, ready_q;
   logic [DATA_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;
   pipe_entry_reg #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_skid (
      .clk, .rst_n, .load(skid_load), .clear(skid_clr),
      .d_data(in_if.data), .d_tag(in_if.tag),
      .valid(skid_valid), .data(skid_data), .tag(skid_tag)
   );
   // Registered ready: no combinational path from out_ready to in_ready.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ready_q <= 1'b1;
      else ready_q <= state_d != SKID;
   assign in_if.ready = ready_q;
   assign head_src_data = skid_valid ? skid_data : in_if.data;
   assign head_src_tag = skid_valid ? skid_tag : in_if.tag;
`else
   assign in_if.ready = out_if.ready | ~head_valid;
   assign head_src_data = in_if.data;
   assign head_src_tag = in_if.tag;
`endif
   pipe_entry_reg #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_head (
      .clk, .rst_n, .load(head_load), .clear(head_clr),
      .d_data(head_src_data), .d_tag(head_src_tag),
      .valid(head_valid), .data(head_data), .tag(head_tag)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= EMPTY;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      head_load = 1'b0;
      head_clr = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_load = 1'b0;
      skid_clr = 1'b0;
`endif
      case (state_q)
         EMPTY: begin
            head_load = accept;
            state_d = accept ? FULL : EMPTY;
         end
         FULL: begin
            // Without the skid entry an accept in FULL always implies a consume.
            head_load = accept & consume;
            head_clr = consume & ~accept;
            state_d = head_clr ? EMPTY : FULL;
`ifdef PIPE_STAGE_SKID_EN
            skid_load = accept & ~consume;
            if (skid_load) state_d = SKID;
`endif
         end
`ifdef PIPE_STAGE_SKID_EN
         SKID: begin
            head_load = consume;
            skid_clr = consume;
            state_d = consume ? FULL : SKID;
         end
`endif
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         head_load = 1'b0;
         head_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         skid_load = 1'b0;
         skid_clr = 1'b1;
`endif
      end
   end
   assign out_if.valid = head_valid;
   assign out_if.data = head_valid ? head_data : NOP_VAL;
   assign out_if.tag = head_valid ? head_tag : '0;
   assign occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks against a FIFO-queue model of the stage.
module tb_pipe_stage_reg;
   typedef struct packed {logic [17:0] d; logic [9:0] t;} ent_t;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID_EN = 1'b1;
`else
   localparam bit SKID_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic [1:0] occupancy;
   int total = 0;
   int passed = 0;
   ent_t q[$];
   pipe_stage_reg_if #(.DATA_W(18), .TAG_W(10)) up();
   pipe_stage_reg_if #(.DATA_W(18), .TAG_W(10)) down();
   pipe_stage_reg dut (.clk(clk), .rst_n(rst_n), .in_if(up), .out_if(down), .flush(flush), .occupancy(occupancy));
   always #5 clk = ~clk;
   task automatic drive(input logic v, input logic [17:0] d, input logic [9:0] t, input logic r, input logic f);
      up.valid = v;
      up.data = d;
      up.tag = t;
      down.ready = r;
      flush = f;
      #1;
   endtask
   function automatic logic exp_ready();
      return SKID_EN ? (q.size() < 2) : (down.ready || q.size() == 0);
   endfunction
   // Model: stage is a FIFO of capacity 1 (or 2 with skid); flush empties it.
   task automatic clock();
      logic acc, con;
      ent_t e;
      acc = up.valid && exp_ready();
      con = q.size() > 0 && down.ready;
      e = '{d: up.data, t: up.tag};
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (con) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
   endtask
   task automatic test_reset();
      drive(1'b1, 18'h3ABCD, 10'h155, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      total++; if (down.valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", down.valid); else passed++;
      total++; if (down.data !== 18'h0) $display("FAIL reset_data got %h exp 0", down.data); else passed++;
      total++; if (down.tag !== 10'h0) $display("FAIL reset_tag got %h exp 0", down.tag); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occupancy); else passed++;
      drive(1'b0, 18'h0, 10'h0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (up.ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", up.ready); else passed++;
   endtask
   task automatic test_stream();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 18'(i), 10'h00F + 10'(i), 1'b1, 1'b0);
         total++; if (up.ready !== 1'b1) $display("FAIL stream_ready%0d got %b exp 1", i, up.ready); else passed++;
         clock();
         total++; if (down.valid !== 1'b1) $display("FAIL stream_valid%0d got %b exp 1", i, down.valid); else passed++;
         total++; if (down.data !== 18'(i)) $display("FAIL stream_data%0d got %h exp %h", i, down.data, 18'(i)); else passed++;
         total++; if (down.tag !== 10'h00F + 10'(i)) $display("FAIL stream_tag%0d got %h exp %h", i, down.tag, 10'h00F + 10'(i)); else passed++;
      end
      drive(1'b0, 18'h0, 10'h0, 1'b1, 1'b0);
      clock();
      total++; if (down.valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", down.valid, occupancy); else passed++;
   endtask
   task automatic test_stall();
      drive(1'b1, 18'h00042, 10'h020, 1'b0, 1'b0);
      clock();
      total++; if (down.data !== 18'h00042 || occupancy !== 2'd1) $display("FAIL stall_first got d=%h occ=%0d exp d=00042 occ=1", down.data, occupancy); else passed++;
      drive(1'b1, 18'h00043, 10'h021, 1'b0, 1'b0);
      total++; if (up.ready !== SKID_EN) $display("FAIL stall_ready1 got %b exp %b", up.ready, SKID_EN); else passed++;
      clock();
      total++; if (occupancy !== (SKID_EN ? 2'd2 : 2'd1)) $display("FAIL stall_occ got %0d exp %0d", occupancy, SKID_EN ? 2 : 1); else passed++;
      total++; if (up.ready !== 1'b0) $display("FAIL stall_ready2 got %b exp 0", up.ready); else passed++;
      repeat (2) clock();
      total++; if (down.data !== 18'h00042 || down.tag !== 10'h020) $display("FAIL stall_hold got d=%h t=%h exp d=00042 t=020", down.data, down.tag); else passed++;
   endtask
   task automatic test_release();
      drive(1'b0, 18'h0, 10'h0, 1'b1, 1'b0);
      clock();
      total++; if (down.data !== (SKID_EN ? 18'h00043 : 18'h0)) $display("FAIL release_data got %h exp %h", down.data, SKID_EN ? 18'h00043 : 18'h0); else passed++;
      total++; if (occupancy !== (SKID_EN ? 2'd1 : 2'd0)) $display("FAIL release_occ1 got %0d exp %0d", occupancy, SKID_EN ? 1 : 0); else passed++;
      clock();
      total++; if (occupancy !== 2'd0 || down.valid !== 1'b0) $display("FAIL release_occ0 got occ=%0d v=%b exp occ=0 v=0", occupancy, down.valid); else passed++;
   endtask
   task automatic test_flush();
      drive(1'b1, 18'h00055, 10'h030, 1'b0, 1'b0);
      clock();
      drive(1'b1, 18'h00056, 10'h031, 1'b0, 1'b0);
      clock();
      drive(1'b1, 18'h3FFFF, 10'h3FF, 1'b0, 1'b1);
      clock();
      total++; if (down.valid !== 1'b0 || down.data !== 18'h0 || down.tag !== 10'h0) $display("FAIL flush_out got v=%b d=%h t=%h exp v=0 d=0 t=0", down.valid, down.data, down.tag); else passed++;
      total++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occupancy); else passed++;
      drive(1'b0, 18'h0, 10'h0, 1'b1, 1'b0);
      clock();
      total++; if (down.valid !== 1'b0 || down.data === 18'h3FFFF) $display("FAIL flush_ghost got v=%b d=%h exp v=0 d=0", down.valid, down.data); else passed++;
      drive(1'b1, 18'h00077, 10'h040, 1'b1, 1'b0);
      clock();
      drive(1'b1, 18'h00078, 10'h041, 1'b1, 1'b1);
      clock();
      total++; if (down.valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL flush_consume got v=%b occ=%0d exp v=0 occ=0", down.valid, occupancy); else passed++;
   endtask
   task automatic test_async_reset();
      drive(1'b1, 18'h00099, 10'h050, 1'b0, 1'b0);
      clock();
      drive(1'b0, 18'h0, 10'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (down.valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL async_reset got v=%b occ=%0d exp v=0 occ=0", down.valid, occupancy); else passed++;
      q.delete();
      #1;
      rst_n = 1'b1;
      clock();
      total++; if (down.valid !== 1'b0 || down.data !== 18'h0) $display("FAIL async_lost got v=%b d=%h exp v=0 d=0", down.valid, down.data); else passed++;
   endtask
   task automatic test_random();
      logic ev;
      logic [17:0] ed;
      logic [9:0] et;
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 18'($urandom), 10'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
         total++; if (up.ready !== exp_ready()) $display("FAIL rand_ready@%0d got %b exp %b", n, up.ready, exp_ready()); else passed++;
         clock();
         ev = q.size() != 0;
         ed = 18'h0;
         et = 10'h0;
         if (ev) begin
            ed = q[0].d;
            et = q[0].t;
         end
         total++; if (down.valid !== ev) $display("FAIL rand_valid@%0d got %b exp %b", n, down.valid, ev); else passed++;
         total++; if (down.data !== ed || down.tag !== et) $display("FAIL rand_entry@%0d got %h/%h exp %h/%h", n, down.data, down.tag, ed, et); else passed++;
         total++; if (occupancy !== 2'(q.size())) $display("FAIL rand_occ@%0d got %0d exp %0d", n, occupancy, q.size()); else passed++;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_release();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
